fp_special_encode: RTL and testbench

//  Output packer for the IEEE754 single-precision ADD/SUB datapath: inverse of the Zero/Inf/NaN classifier.

---
 rtl/fp_special_encode.sv | 128 ++++++++++++
 tb/tb_fp_special_encode.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_special_encode.sv
// Output packer for the IEEE754 single ADD/SUB path: forces Zero/Inf/NaN encodings, flags ovf/unf/nan (FP_NAN_PAYLOAD_EN keeps NaN payload).
// Latency 2 clk (S1 precompute, S2 output register); throughput 1 word/clk.
// Backpressure: S2 holds while out_valid&~out_ready; in_ready drops only when both stages are full and stalled.
module fp_special_encode #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_class,
    input  logic             in_sign,
    input  logic [7:0]       in_exp,
    input  logic [22:0]      in_frac,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_word,
    input  logic             flag_clr,
    output logic             flag_ovf,
    output logic             flag_unf,
    output logic             flag_nan,
    output logic [CNT_W-1:0] nan_cnt
);
    localparam logic [1:0] CLS_ZERO = 2'd1;
    localparam logic [1:0] CLS_INF  = 2'd2;
    localparam logic [1:0] CLS_NAN  = 2'd3;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [31:0] enc_word;
    logic        enc_ovf, enc_unf, enc_nan;

    logic        s1_v;
    logic [31:0] s1_word;
    logic        s1_ovf, s1_unf, s1_nan;
    logic        s2_v;
    logic        s2_ovf, s2_unf, s2_nan;

    logic        s2_load, in_fire, out_fire;

    always_comb begin
        enc_word = {in_sign, in_exp, in_frac};
        enc_ovf  = 1'b0;
        enc_unf  = 1'b0;
        enc_nan  = 1'b0;
        case (in_class)
            CLS_ZERO: enc_word = {in_sign, 31'h0};
            CLS_INF:  enc_word = {in_sign, 8'hFF, 23'h0};
            CLS_NAN: begin
`ifdef FP_NAN_PAYLOAD_EN
                enc_word = {in_sign, 8'hFF, 1'b1, in_frac[21:0]};
`else
                enc_word = 32'h7FC0_0000;
`endif
                enc_nan  = 1'b1;
            end
            default: begin
                if (in_exp == 8'hFF) begin
                    enc_word = {in_sign, 8'hFF, 23'h0};
                    enc_ovf  = 1'b1;
                end else if (in_exp == 8'h00) begin
                    // Denormals are not representable downstream: flush, tag only if a real value was lost
                    enc_word = {in_sign, 31'h0};
                    enc_unf  = (in_frac != 23'h0);
                end
            end
        endcase
    end

    assign s2_load   = ~s2_v | out_ready;
    assign in_ready  = ~s1_v | s2_load;
    assign in_fire   = in_valid & in_ready;
    assign out_valid = s2_v;
    assign out_fire  = s2_v & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v     <= 1'b0;
            s1_word  <= 32'h0;
            s1_ovf   <= 1'b0;
            s1_unf   <= 1'b0;
            s1_nan   <= 1'b0;
            s2_v     <= 1'b0;
            out_word <= 32'h0;
            s2_ovf   <= 1'b0;
            s2_unf   <= 1'b0;
            s2_nan   <= 1'b0;
            flag_ovf <= 1'b0;
            flag_unf <= 1'b0;
            flag_nan <= 1'b0;
            nan_cnt  <= '0;
        end else begin
            if (s2_load) begin
                s2_v <= s1_v;
                if (s1_v) begin
                    out_word <= s1_word;
                    s2_ovf   <= s1_ovf;
                    s2_unf   <= s1_unf;
                    s2_nan   <= s1_nan;
                end
            end

            if (in_fire) begin
                s1_v    <= 1'b1;
                s1_word <= enc_word;
                s1_ovf  <= enc_ovf;
                s1_unf  <= enc_unf;
                s1_nan  <= enc_nan;
            end else if (s2_load) begin
                s1_v <= 1'b0;
            end

            // Flags record what actually left the block; a same-cycle set beats the clear
            if (out_fire & s2_ovf)  flag_ovf <= 1'b1;
            else if (flag_clr)      flag_ovf <= 1'b0;
            if (out_fire & s2_unf)  flag_unf <= 1'b1;
            else if (flag_clr)      flag_unf <= 1'b0;
            if (out_fire & s2_nan)  flag_nan <= 1'b1;
            else if (flag_clr)      flag_nan <= 1'b0;

            if (out_fire & s2_nan) begin
                if (flag_clr)           nan_cnt <= CNT_ONE;
                else if (nan_cnt != '1) nan_cnt <= nan_cnt + CNT_ONE;
            end else if (flag_clr) begin
                nan_cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_fp_special_encode.sv
// Bench for fp_special_encode: expected-word queue plus flag model checked every cycle, with literal spot checks.
module tb_fp_special_encode;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [1:0]       in_class = 2'd0;
    logic             in_sign = 1'b0;
    logic [7:0]       in_exp = 8'h0;
    logic [22:0]      in_frac = 23'h0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [31:0]      out_word;
    logic             flag_clr = 1'b0;
    logic             flag_ovf, flag_unf, flag_nan;
    logic [CNT_W-1:0] nan_cnt;

    fp_special_encode #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_class(in_class), .in_sign(in_sign), .in_exp(in_exp), .in_frac(in_frac),
        .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
        .flag_clr(flag_clr), .flag_ovf(flag_ovf), .flag_unf(flag_unf),
        .flag_nan(flag_nan), .nan_cnt(nan_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] w;
        logic        ovf;
        logic        unf;
        logic        nan;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    bit   m_ovf = 0, m_unf = 0, m_nan = 0;
    int   m_cnt = 0;
    bit   started = 0, done = 0, saw_full = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, req, $time);
        end
    endtask

    // Expected result straight from the class/exponent rules, as integers
    function automatic exp_t model(int cls, bit s, int e, int f);
        exp_t r;
        int   sbit;
        sbit = s ? 32'h8000_0000 : 0;
        r = '0;
        if (cls == 3) begin
`ifdef FP_NAN_PAYLOAD_EN
            r.w = sbit | 32'h7FC0_0000 | (f & 32'h003F_FFFF);
`else
            r.w = 32'h7FC0_0000;
`endif
            r.nan = 1;
        end else if (cls == 2) begin
            r.w = sbit | 32'h7F80_0000;
        end else if (cls == 1) begin
            r.w = sbit;
        end else if (e == 255) begin
            r.w = sbit | 32'h7F80_0000;
            r.ovf = 1;
        end else if (e == 0) begin
            r.w = sbit;
            r.unf = (f != 0);
        end else begin
            r.w = sbit | (e * 32'h0080_0000) | f;
        end
        return r;
    endfunction

    task automatic send(int cls, bit s, int e, int f);
        bit ok = 0;
        in_valid = 1'b1;
        in_class = cls[1:0];
        in_sign  = s;
        in_exp   = e[7:0];
        in_frac  = f[22:0];
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready never high at %0t", $time);
        end
        in_valid = 1'b0;
    endtask

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Per-cycle compare against the model, sampled mid-cycle
    initial begin : monitor
        bit          prev_stall = 0;
        logic [31:0] prev_word  = 32'h0;
        exp_t        e;
        wait (started);
        while (!done) begin
            @(negedge clk);
            chk("flag_ovf", {31'h0, flag_ovf}, {31'h0, m_ovf});
            chk("flag_unf", {31'h0, flag_unf}, {31'h0, m_unf});
            chk("flag_nan", {31'h0, flag_nan}, {31'h0, m_nan});
            chk("nan_cnt", 32'(nan_cnt), 32'(m_cnt));
            chk("in_ready", {31'h0, in_ready}, {31'h0, (q.size() < 2) || out_ready});
            if (q.size() == 0) chk("idle_out_valid", {31'h0, out_valid}, 32'h0);
            if (prev_stall) begin
                chk("stall_valid", {31'h0, out_valid}, 32'h1);
                chk("stall_word", out_word, prev_word);
            end
            if (!in_ready) saw_full = 1;
            if (rst) begin
                q.delete();
                m_ovf = 0; m_unf = 0; m_nan = 0; m_cnt = 0;
                prev_stall = 0;
            end else begin
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        chk("unexpected_word", out_word, 32'hDEAD_DEAD);
                        e = '0;
                    end else begin
                        e = q.pop_front();
                        chk("out_word", out_word, e.w);
                    end
                end else begin
                    e = '0;
                end
                if (e.ovf) m_ovf = 1; else if (flag_clr) m_ovf = 0;
                if (e.unf) m_unf = 1; else if (flag_clr) m_unf = 0;
                if (e.nan) begin
                    m_nan = 1;
                    m_cnt = flag_clr ? 1 : (m_cnt < CNT_MAX ? m_cnt + 1 : CNT_MAX);
                end else if (flag_clr) begin
                    m_nan = 0;
                    m_cnt = 0;
                end
                if (in_valid && in_ready)
                    q.push_back(model(in_class, in_sign, in_exp, in_frac));
                prev_stall = out_valid && !out_ready;
                prev_word  = out_word;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        tick(3);
        rst = 1'b0;
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_out_word", out_word, 32'h0);
        chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
        chk("rst_flags", {29'h0, flag_ovf, flag_unf, flag_nan}, 32'h0);
        chk("rst_cnt", 32'(nan_cnt), 32'h0);
        started = 1;

        // T1: 1.0f, two clocks of latency
        send(0, 0, 8'h7F, 0);
        tick(1);
        chk("t1_valid", {31'h0, out_valid}, 32'h1);
        chk("t1_word", out_word, 32'h3F80_0000);
        tick(1);
        chk("t1_flags", {29'h0, flag_ovf, flag_unf, flag_nan}, 32'h0);

        // T2: overflow then denormal flush
        send(0, 1, 8'hFF, 5);
        tick(1);
        chk("t2_ovf_word", out_word, 32'hFF80_0000);
        send(0, 1, 8'h00, 1);
        tick(1);
        chk("t2_unf_word", out_word, 32'h8000_0000);
        tick(1);
        chk("t2_flag_ovf", {31'h0, flag_ovf}, 32'h1);
        chk("t2_flag_unf", {31'h0, flag_unf}, 32'h1);

        // T3: NaN with payload
        send(3, 1, 0, 23'h12345);
        tick(1);
`ifdef FP_NAN_PAYLOAD_EN
        chk("t3_nan_word", out_word, 32'hFFC1_2345);
`else
        chk("t3_nan_word", out_word, 32'h7FC0_0000);
`endif
        tick(1);
        chk("t3_flag_nan", {31'h0, flag_nan}, 32'h1);
        chk("t3_nan_cnt", 32'(nan_cnt), 32'h1);

        // T4: 8-word stream with out_ready 1,0,0 repeating
        saw_full = 0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    if (i == 5)      send(1, 1, 0, 0);
                    else if (i == 6) send(2, 0, 0, 0);
                    else             send(0, i[0], 8'h40 + i, i * 3 + 1);
                end
            end
            begin
                for (int c = 0; c < 30; c++) begin
                    out_ready = (c % 3 == 0);
                    tick(1);
                end
            end
        join
        out_ready = 1'b1;
        tick(4);
        chk("t4_saw_full", {31'h0, saw_full}, 32'h1);
        chk("t4_drained", {31'h0, out_valid}, 32'h0);

        // T5: clear collides with NaN transfer, then clear alone
        send(3, 0, 0, 7);
        tick(1);
        flag_clr = 1'b1;
        tick(1);
        flag_clr = 1'b0;
        chk("t5_set_wins_nan", {31'h0, flag_nan}, 32'h1);
        chk("t5_set_wins_cnt", 32'(nan_cnt), 32'h1);
        chk("t5_clr_ovf", {31'h0, flag_ovf}, 32'h0);
        flag_clr = 1'b1;
        tick(1);
        flag_clr = 1'b0;
        chk("t5_clr_all", {28'h0, nan_cnt != 0, flag_ovf, flag_unf, flag_nan}, 32'h0);

        // T6: reset with two words in flight
        send(3, 0, 0, 0);
        tick(3);
        out_ready = 1'b0;
        send(0, 0, 8'h10, 0);
        send(0, 0, 8'h11, 0);
        chk("t6_full", {31'h0, in_ready}, 32'h0);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        out_ready = 1'b1;
        chk("t6_out_valid", {31'h0, out_valid}, 32'h0);
        chk("t6_in_ready", {31'h0, in_ready}, 32'h1);
        chk("t6_flags", {29'h0, flag_ovf, flag_unf, flag_nan}, 32'h0);
        send(0, 0, 8'h81, 23'h100);
        tick(1);
        chk("t6_first_word", out_word, 32'h4080_0100);

        // Counter saturation
        for (int i = 0; i < CNT_MAX + 1; i++) send(3, i[0], 0, i);
        tick(4);
        chk("t6_cnt_sat", 32'(nan_cnt), 32'(CNT_MAX));
        chk("t6_drained", {31'h0, out_valid}, 32'h0);

        done = 1;
        @(negedge clk);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
